// File: rtl/hud_layer_mux.sv
// HUD layer priority mux: masked, blinking, optionally colour-keyed channels merged into one
// registered draw request. Optional colour keying is enabled by defining HUD_COLORKEY_EN.
module hud_lane #(
   parameter int                 RGB_W       = 8,
   parameter logic [RGB_W-1:0]   TRANSPARENT = 8'hFF
) (
   input  logic             dr,
   input  logic [RGB_W-1:0] rgb,
   input  logic             en,
   input  logic             blinks,
   input  logic             phase,
   output logic             eff
);
`ifdef HUD_COLORKEY_EN
   assign eff = dr & en & (~blinks | phase) & (rgb != TRANSPARENT);
`else
   logic unused_rgb;
   assign unused_rgb = ^{rgb, TRANSPARENT};
   assign eff        = dr & en & (~blinks | phase);
`endif
endmodule

module hud_layer_mux #(
   parameter int                 CHANNELS     = 8,
   parameter int                 RGB_W        = 8,
   parameter logic [RGB_W-1:0]   TRANSPARENT  = 8'hFF,
   parameter int                 BLINK_FRAMES = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      startOfFrame,
   input  logic [CHANNELS-1:0]       chanDR,
   input  logic [CHANNELS*RGB_W-1:0] chanRGB,
   input  logic                      maskWrite,
   input  logic [CHANNELS-1:0]       maskData,
   input  logic                      blinkWrite,
   input  logic [CHANNELS-1:0]       blinkData,
   output logic                      metadataDR,
   output logic [RGB_W-1:0]          metadataRGB,
   output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] hitChan,
   output logic [CHANNELS-1:0]       frameHits
);
   localparam int HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int FW = $clog2(BLINK_FRAMES) + 1;

   logic [CHANNELS-1:0] mask, blinkSel, hitAcc, eff;
   logic [FW-1:0]       frameCnt;
   logic                blinkPhase;
   logic                win_dr;
   logic [RGB_W-1:0]    win_rgb;
   logic [HW-1:0]       win_idx;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      hud_lane #(.RGB_W(RGB_W), .TRANSPARENT(TRANSPARENT)) u_lane (
         .dr     (chanDR[i]),
         .rgb    (chanRGB[i*RGB_W +: RGB_W]),
         .en     (mask[i]),
         .blinks (blinkSel[i]),
         .phase  (blinkPhase),
         .eff    (eff[i])
      );
   end

   // Scan high to low so the lowest effective index is the last (winning) assignment.
   always_comb begin
      win_dr  = 1'b0;
      win_rgb = '0;
      win_idx = '0;
      for (int i = CHANNELS-1; i >= 0; i--) begin
         if (eff[i]) begin
            win_dr  = 1'b1;
            win_rgb = chanRGB[i*RGB_W +: RGB_W];
            win_idx = HW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask        <= '1;
         blinkSel    <= '0;
         frameCnt    <= '0;
         blinkPhase  <= 1'b1;
         hitAcc      <= '0;
         frameHits   <= '0;
         metadataDR  <= 1'b0;
         metadataRGB <= '0;
         hitChan     <= '0;
      end else begin
         metadataDR  <= win_dr;
         metadataRGB <= win_rgb;
         hitChan     <= win_idx;
         if (maskWrite)  mask     <= maskData;
         if (blinkWrite) blinkSel <= blinkData;
         // The pulse cycle's own requests belong to the frame that is ending.
         if (startOfFrame) begin
            frameHits <= hitAcc | eff;
            hitAcc    <= '0;
            if (frameCnt == FW'(BLINK_FRAMES-1)) begin
               frameCnt   <= '0;
               blinkPhase <= ~blinkPhase;
            end else begin
               frameCnt <= frameCnt + 1'b1;
            end
         end else begin
            hitAcc <= hitAcc | eff;
         end
      end
   end
endmodule

// File: tb/tb_hud_layer_mux.sv
// Randomized and directed bench for hud_layer_mux against a frame-counting reference model.
module tb_hud_layer_mux;
   localparam int CH = 8;
   localparam int BF = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            startOfFrame;
   logic [CH-1:0]   chanDR;
   logic [CH*8-1:0] chanRGB;
   logic            maskWrite, blinkWrite;
   logic [CH-1:0]   maskData, blinkData;
   logic            metadataDR;
   logic [7:0]      metadataRGB;
   logic [2:0]      hitChan;
   logic [CH-1:0]   frameHits;

   int checks = 0;
   int fails  = 0;

   // reference model state
   logic [CH-1:0] m_mask, m_blink, m_acc;
   int            m_sof;
   logic          e_dr;
   logic [7:0]    e_rgb;
   logic [2:0]    e_hit;
   logic [CH-1:0] e_fh;

   hud_layer_mux #(.CHANNELS(CH), .RGB_W(8), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .chanDR(chanDR), .chanRGB(chanRGB),
      .maskWrite(maskWrite), .maskData(maskData),
      .blinkWrite(blinkWrite), .blinkData(blinkData),
      .metadataDR(metadataDR), .metadataRGB(metadataRGB),
      .hitChan(hitChan), .frameHits(frameHits)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mask = '1; m_blink = '0; m_acc = '0; m_sof = 0;
      e_dr = 1'b0; e_rgb = '0; e_hit = '0; e_fh = '0;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".dr"},  32'(metadataDR),  32'(e_dr));
      chk({tag, ".rgb"}, 32'(metadataRGB), 32'(e_rgb));
      chk({tag, ".hit"}, 32'(hitChan),     32'(e_hit));
      chk({tag, ".fh"},  32'(frameHits),   32'(e_fh));
   endtask

   // One clock: apply inputs, predict from the rules, then sample after the edge.
   task automatic cycle(input string tag, input logic [CH-1:0] dr, input logic [CH*8-1:0] rgb,
                        input logic sof, input logic mw, input logic [CH-1:0] md,
                        input logic bw, input logic [CH-1:0] bd);
      logic          vis, found;
      logic [CH-1:0] eff;
      logic [7:0]    c;
      chanDR = dr; chanRGB = rgb; startOfFrame = sof;
      maskWrite = mw; maskData = md; blinkWrite = bw; blinkData = bd;
      vis = ((m_sof / BF) % 2) == 0;
      eff = '0;
      for (int i = 0; i < CH; i++) begin
         c = rgb[i*8 +: 8];
         eff[i] = dr[i] && m_mask[i] && (!m_blink[i] || vis);
`ifdef HUD_COLORKEY_EN
         if (c == 8'hFF) eff[i] = 1'b0;
`endif
      end
      found = 1'b0; e_dr = 1'b0; e_rgb = '0; e_hit = '0;
      for (int i = 0; i < CH; i++) begin
         if (eff[i] && !found) begin
            found = 1'b1; e_dr = 1'b1; e_rgb = rgb[i*8 +: 8]; e_hit = 3'(i);
         end
      end
      m_acc = m_acc | eff;
      if (sof) begin
         e_fh = m_acc; m_acc = '0; m_sof++;
      end
      if (mw) m_mask  = md;
      if (bw) m_blink = bd;
      @(posedge clk); #1;
      check_outs(tag);
   endtask

   task automatic idle(input string tag, input logic [CH-1:0] dr, input logic [CH*8-1:0] rgb,
                       input logic sof);
      cycle(tag, dr, rgb, sof, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      logic [CH*8-1:0] rgb;
      logic [CH-1:0]   dr;
      reset = 1'b1; startOfFrame = 1'b0; chanDR = '0; chanRGB = '0;
      maskWrite = 1'b0; maskData = '0; blinkWrite = 1'b0; blinkData = '0;
      model_reset();
      #12;
      check_outs("reset");
      reset = 1'b0;

      // priority: ch1 beats ch2, then nothing drawing
      rgb = '0; rgb[15:8] = 8'h1C; rgb[23:16] = 8'hE0;
      idle("prio", 8'b0000_0110, rgb, 1'b0);
      chk("prio.rgb1C", 32'(metadataRGB), 32'h1C);
      idle("nodr", 8'h00, rgb, 1'b0);

      // mask ch1 off, ch2 now wins
      cycle("maskwr", 8'h00, rgb, 1'b0, 1'b1, 8'hFD, 1'b0, '0);
      idle("mask", 8'h06, rgb, 1'b0);
      chk("mask.hit2", 32'(hitChan), 32'd2);
      cycle("unmask", 8'h00, rgb, 1'b0, 1'b1, 8'hFF, 1'b0, '0);

      // blink ch0 across frames 0..4 (counted from reset)
      rgb = '0; rgb[7:0] = 8'h42;
      cycle("blinkwr", 8'h01, rgb, 1'b0, 1'b0, '0, 1'b1, 8'h01);
      for (int f = 0; f < 5; f++) begin
         idle("blink", 8'h01, rgb, 1'b0);
         chk("blink.vis", 32'(metadataDR), 32'((m_sof % 4) < 2));
         idle("blink", 8'h01, rgb, 1'b0);
         idle("blink.sof", 8'h01, rgb, 1'b1);
      end
      cycle("blinkclr", 8'h00, rgb, 1'b0, 1'b0, '0, 1'b1, 8'h00);

      // colour key: ch0 keyed, ch3 behind it
      rgb = '0; rgb[7:0] = 8'hFF; rgb[31:24] = 8'h03;
      idle("key.sof", 8'h00, rgb, 1'b1);
      idle("key", 8'h09, rgb, 1'b0);
`ifdef HUD_COLORKEY_EN
      chk("key.on", 32'(metadataRGB), 32'h03);
`else
      chk("key.off", 32'(metadataRGB), 32'hFF);
`endif
      idle("key.sof2", 8'h00, rgb, 1'b1);

      // frame hits: ch5 only in the pulse cycle, then an empty frame
      rgb = '0; rgb[47:40] = 8'hA5;
      idle("fh.mid", 8'h00, rgb, 1'b0);
      idle("fh.sof", 8'h20, rgb, 1'b1);
      chk("fh.20", 32'(frameHits), 32'h20);
      idle("fh.idle", 8'h00, rgb, 1'b0);
      idle("fh.sof2", 8'h00, rgb, 1'b1);

      // mid-frame async reset with altered mask/blink state
      rgb = '0; rgb[7:0] = 8'h55;
      cycle("rst.setup", 8'h01, rgb, 1'b0, 1'b1, 8'hFE, 1'b1, 8'h01);
      idle("rst.pre", 8'h01, rgb, 1'b0);
      #2 reset = 1'b1;
      #1 model_reset();
      check_outs("rst.async");
      #2 reset = 1'b0;
      idle("rst.post", 8'h01, rgb, 1'b0);
      chk("rst.mask", 32'(metadataDR), 32'd1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         dr  = CH'($urandom);
         rgb = {$urandom, $urandom};
         for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 5) == 0) rgb[i*8 +: 8] = 8'hFF;
         cycle("rand", dr, rgb, $urandom_range(0, 15) == 0,
               $urandom_range(0, 19) == 0, CH'($urandom) | CH'($urandom),
               $urandom_range(0, 19) == 0, CH'($urandom) & CH'($urandom));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/hud_layer_mux.md
# hud_layer_mux

Parametrised, registered priority multiplexer for the HUD/metadata layer. It merges `CHANNELS` sprite-style drawing requests (timer, lives, bombs, score, level, per-player counters, and future widgets) into one `metadataDR`/`metadataRGB` pair. It adds per-channel runtime enable masking, frame-synchronous blinking, and per-frame hit reporting. It sits between the individual HUD object drawers and the top-level video mux, adding one pipeline stage.

## Interface
Parameters:
- `CHANNELS`, 8: number of input layers; index 0 has highest priority.
- `RGB_W`, 8: pixel colour width.
- `TRANSPARENT`, 8'hFF: colour-key value, `RGB_W` bits wide. Used only with `HUD_COLORKEY_EN`.
- `BLINK_FRAMES`, 16: frames per blink half-period, ≥1.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle pulse at frame start.
- `chanDR`, in, `CHANNELS`: per-channel draw request.
- `chanRGB`, in, `CHANNELS*RGB_W`: packed colours; channel i occupies bits [i*RGB_W +: RGB_W].
- `maskWrite`, in, 1: load `maskData` into the enable mask.
- `maskData`, in, `CHANNELS`: 1 = channel enabled.
- `blinkWrite`, in, 1: load `blinkData` into the blink-select register.
- `blinkData`, in, `CHANNELS`: 1 = channel blinks.
- `metadataDR`, out, 1: registered merged draw request.
- `metadataRGB`, out, `RGB_W`: registered merged colour.
- `hitChan`, out, max(1,$clog2(CHANNELS)): registered index of the winning channel.
- `frameHits`, out, `CHANNELS`: channels that drew at least once in the previous frame.

## Operation
- Internal registers and their reset values:
  - `mask`: all ones.
  - `blinkSel`: all zeros.
  - `frameCnt`: 0. Width is $clog2(BLINK_FRAMES)+1.
  - `blinkPhase`: 1 (visible).
  - `hitAcc`: 0.
- Effective request for channel i, `eff[i]`, is `chanDR[i] & mask[i] & (~blinkSel[i] | blinkPhase)`. With `HUD_COLORKEY_EN`, it is additionally ANDed with `chanRGB[i] != TRANSPARENT`.
- Winner selection: the lowest i with `eff[i]=1` wins.
  - Next `metadataDR` = 1, next `metadataRGB` = `chanRGB[i]`, next `hitChan` = i.
  - If no channel is effective: DR=0, RGB=0, hitChan=0.
- Blink counter, on each `startOfFrame`:
  - If `frameCnt == BLINK_FRAMES-1`: `frameCnt` ← 0 and `blinkPhase` toggles.
  - Otherwise: `frameCnt` increments.
  - With `BLINK_FRAMES=1`, the phase toggles every frame.
- Hit accumulation:
  - Every cycle: `hitAcc |= eff`.
  - On `startOfFrame`: `frameHits` ← `hitAcc | eff` (the pulse cycle counts toward the ending frame), and `hitAcc` ← 0.
- Register writes:
  - `maskWrite`/`blinkWrite` update their register at the clock edge.
  - The new value affects `eff` from the following cycle.
  - A write in the same cycle as `startOfFrame` uses the old value for that cycle's hit capture.
- Simultaneous `maskWrite` and `blinkWrite` are independent; both take effect.
- Asserting `reset` mid-frame immediately restores all reset values. `frameHits` then reports 0 until the next `startOfFrame`.

## Timing
- Latency of 1 clock from `chanDR`/`chanRGB` to `metadataDR`/`metadataRGB`/`hitChan`. Upstream drawers' coordinates must be delayed by 1 at the top level.
- `frameHits` changes only on the edge sampling `startOfFrame` and is stable for the whole frame.
- Blink phase changes on the edge sampling `startOfFrame`. Pixels within a frame never see a phase change.
- Output reset values: `metadataDR`=0, `metadataRGB`=0, `hitChan`=0, `frameHits`=0.
- No combinational path from inputs to outputs.

## Configuration
- `HUD_COLORKEY_EN` defined:
  - A channel whose pixel equals `TRANSPARENT` is treated as not drawing.
  - Lower-priority channels show through, and that channel is excluded from `hitAcc`.
- `HUD_COLORKEY_EN` undefined:
  - `chanDR` alone qualifies a channel, and `TRANSPARENT` is unused.
  - A keyed colour is output verbatim.

## Test plan
- Priority: reset released, `chanDR`=8'b0000_0110, ch1 RGB=8'h1C, ch2 RGB=8'hE0 -> next cycle `metadataDR`=1, `metadataRGB`=8'h1C, `hitChan`=1. With no DR, all outputs are 0.
- Mask: `maskWrite`=1, `maskData`=8'hFD, then `chanDR`=8'h06 -> output RGB 8'hE0, `hitChan`=2.
- Blink: `BLINK_FRAMES`=2, `blinkData`=8'h01, ch0 drawing constantly -> ch0 visible for frames 0–1, hidden for frames 2–3 (output 0 if alone), visible again in frame 4.
- Colour key (macro on): ch0 RGB=8'hFF with DR=1, ch3 RGB=8'h03 with DR=1 -> output 8'h03, `hitChan`=3, ch0 absent from the next `frameHits`. Macro off -> output 8'hFF, `hitChan`=0.
- Frame hits: ch5 drawn only in the `startOfFrame` cycle -> `frameHits`=8'h20 after that edge. The following frame with no draws yields 8'h00.
- Reset mid-frame: `reset` pulsed asynchronously while ch0 draws -> outputs 0 immediately, `mask` back to 8'hFF, `blinkPhase`=1.
